// File: rtl/hp_manager.sv
// Player HP owner: arbitrates damage/heal requests, saturates HP, and runs the
// post-hit invulnerability window, game-over state and low-HP blink output.
module hp_manager #(
    parameter int HP_MAX     = 10,
    parameter int LOW_TH     = 3,
    parameter int INVULN_CYC = 50000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       DMG_REQ,
    input  logic [3:0] DMG_AMT,
    input  logic       HEAL_REQ,
    input  logic [3:0] HEAL_AMT,
    output logic [3:0] OUT_HP,
    output logic       DMG_ACK,
    output logic       HEAL_ACK,
    output logic       INVULN,
    output logic       GAME_OVER,
    output logic       LOW_BLINK
);

    localparam int IW = (INVULN_CYC > 2) ? $clog2(INVULN_CYC) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [3:0]    HP_FULL    = 4'(HP_MAX);
    localparam logic [3:0]    LOW_LIM    = 4'(LOW_TH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        INV   = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      hp_r, hp_s;
    logic            dmg_ack_r, dmg_ack_s;
    logic            heal_ack_r, heal_ack_s;
    logic            invuln_r, invuln_s;
    logic            game_over_r, game_over_s;
    logic            blink_r, blink_s;
    logic [IW-1:0]   inv_cnt_r, inv_cnt_s;
    logic [BW-1:0]   blink_cnt_r, blink_cnt_s;

    logic            playing_s;
    logic            dmg_take_s;
    logic            heal_take_s;
    logic [4:0]      heal_sum_s;
    logic [3:0]      healed_s;
    logic [3:0]      hurt_s;
    logic            low_now_s;
    logic            low_next_s;

    // Requests are only taken while playing; an ACK high this cycle blocks re-acceptance.
    assign playing_s   = (state_r == ALIVE) || (state_r == INV);
    assign dmg_take_s  = playing_s && DMG_REQ && !dmg_ack_r;
    assign heal_take_s = playing_s && HEAL_REQ && !heal_ack_r && !dmg_take_s;
    assign heal_sum_s  = {1'b0, hp_r} + {1'b0, HEAL_AMT};
    assign healed_s    = (heal_sum_s > {1'b0, HP_FULL}) ? HP_FULL : heal_sum_s[3:0];
    assign hurt_s      = (DMG_AMT >= hp_r) ? 4'd0 : (hp_r - DMG_AMT);
    assign low_now_s   = playing_s && (hp_r >= 4'd1) && (hp_r <= LOW_LIM);

    // Next-state, HP arithmetic, invulnerability timer and blink generator.
    always_comb begin
        state_s     = state_r;
        hp_s        = hp_r;
        dmg_ack_s   = dmg_take_s;
        heal_ack_s  = heal_take_s;
        invuln_s    = invuln_r;
        game_over_s = game_over_r;
        inv_cnt_s   = inv_cnt_r;
        blink_s     = blink_r;
        blink_cnt_s = blink_cnt_r;
        low_next_s  = 1'b0;

        case (state_r)
            IDLE, DEAD: begin
                if (START) begin
                    state_s     = ALIVE;
                    hp_s        = HP_FULL;
                    game_over_s = 1'b0;
                    invuln_s    = 1'b0;
                    inv_cnt_s   = {IW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ALIVE: begin
                if (dmg_take_s && (DMG_AMT != 4'd0)) begin
                    hp_s = hurt_s;
                    if (hurt_s == 4'd0) begin
                        state_s     = DEAD;
                        game_over_s = 1'b1;
                        invuln_s    = 1'b0;
                    end else begin
                        state_s   = INV;
                        invuln_s  = 1'b1;
                        inv_cnt_s = INV_LOAD;
                    end
                end else if (heal_take_s) begin
                    hp_s = healed_s;
                end else begin
                    hp_s = hp_r;
                end
            end
            INV: begin
                if (heal_take_s) begin
                    hp_s = healed_s;
                end else begin
                    hp_s = hp_r;
                end
                if (inv_cnt_r == {IW{1'b0}}) begin
                    state_s  = ALIVE;
                    invuln_s = 1'b0;
                end else begin
                    inv_cnt_s = inv_cnt_r - IW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        low_next_s = ((state_s == ALIVE) || (state_s == INV)) &&
                     (hp_s >= 4'd1) && (hp_s <= LOW_LIM);

        if (!low_next_s) begin
            blink_s     = 1'b0;
            blink_cnt_s = {BW{1'b0}};
        end else if (!low_now_s) begin
            blink_s     = 1'b1;
            blink_cnt_s = {BW{1'b0}};
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_s     = !blink_r;
            blink_cnt_s = {BW{1'b0}};
        end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            hp_r        <= 4'd0;
            dmg_ack_r   <= 1'b0;
            heal_ack_r  <= 1'b0;
            invuln_r    <= 1'b0;
            game_over_r <= 1'b0;
            blink_r     <= 1'b0;
            inv_cnt_r   <= {IW{1'b0}};
            blink_cnt_r <= {BW{1'b0}};
        end else begin
            state_r     <= state_s;
            hp_r        <= hp_s;
            dmg_ack_r   <= dmg_ack_s;
            heal_ack_r  <= heal_ack_s;
            invuln_r    <= invuln_s;
            game_over_r <= game_over_s;
            blink_r     <= blink_s;
            inv_cnt_r   <= inv_cnt_s;
            blink_cnt_r <= blink_cnt_s;
        end
    end

    assign OUT_HP    = hp_r;
    assign DMG_ACK   = dmg_ack_r;
    assign HEAL_ACK  = heal_ack_r;
    assign INVULN    = invuln_r;
    assign GAME_OVER = game_over_r;
    assign LOW_BLINK = blink_r;

endmodule

// File: tb/tb_hp_manager.sv
// Self-checking bench for hp_manager: a behavioural HP model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hp_manager;

    localparam int HPM  = 10;
    localparam int LOWT = 3;
    localparam int INVC = 8;
    localparam int BH   = 4;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       DMG_REQ;
    logic [3:0] DMG_AMT;
    logic       HEAL_REQ;
    logic [3:0] HEAL_AMT;
    logic [3:0] OUT_HP;
    logic       DMG_ACK;
    logic       HEAL_ACK;
    logic       INVULN;
    logic       GAME_OVER;
    logic       LOW_BLINK;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    // Model: phase 0=idle, 1=playing, 2=dead; inv_left = invulnerable cycles still to show;
    // low_age = cycles spent in low range (-1 when not low).
    int m_phase    = 0;
    int m_hp       = 0;
    int m_dack     = 0;
    int m_hack     = 0;
    int m_inv_left = 0;
    int m_low_age  = -1;

    int inv_run      = 0;
    int last_inv_len = 0;

    hp_manager #(
        .HP_MAX(HPM), .LOW_TH(LOWT), .INVULN_CYC(INVC), .BLINK_HALF(BH)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .DMG_REQ(DMG_REQ), .DMG_AMT(DMG_AMT),
        .HEAL_REQ(HEAL_REQ), .HEAL_AMT(HEAL_AMT),
        .OUT_HP(OUT_HP), .DMG_ACK(DMG_ACK), .HEAL_ACK(HEAL_ACK),
        .INVULN(INVULN), .GAME_OVER(GAME_OVER), .LOW_BLINK(LOW_BLINK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model advanced on each rising edge, reset asynchronously.
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_phase = 0; m_hp = 0; m_dack = 0; m_hack = 0;
                m_inv_left = 0; m_low_age = -1;
            end else begin
                int  hp_n, ph_n, inv_n, age_n;
                bit  dt, ht, low_n;
                dt    = (m_phase == 1) && DMG_REQ && (m_dack == 0);
                ht    = (m_phase == 1) && HEAL_REQ && (m_hack == 0) && !dt;
                hp_n  = m_hp;
                ph_n  = m_phase;
                inv_n = (m_inv_left > 0) ? m_inv_left - 1 : 0;
                if (m_phase != 1) begin
                    if (START) begin
                        ph_n = 1; hp_n = HPM; inv_n = 0;
                    end
                end else if (dt) begin
                    if (m_inv_left == 0 && DMG_AMT != 0) begin
                        hp_n = (m_hp > int'(DMG_AMT)) ? m_hp - int'(DMG_AMT) : 0;
                        if (hp_n == 0) begin
                            ph_n = 2; inv_n = 0;
                        end else begin
                            inv_n = INVC;
                        end
                    end
                end else if (ht) begin
                    hp_n = (m_hp + int'(HEAL_AMT) > HPM) ? HPM : m_hp + int'(HEAL_AMT);
                end
                low_n = (ph_n == 1) && (hp_n >= 1) && (hp_n <= LOWT);
                age_n = !low_n ? -1 : ((m_low_age >= 0) ? m_low_age + 1 : 0);
                m_phase = ph_n; m_hp = hp_n; m_inv_left = inv_n; m_low_age = age_n;
                m_dack = dt ? 1 : 0;
                m_hack = ht ? 1 : 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("out_hp", OUT_HP, m_hp);
                chk("dmg_ack", DMG_ACK, m_dack);
                chk("heal_ack", HEAL_ACK, m_hack);
                chk("invuln", INVULN, (m_inv_left > 0) ? 1 : 0);
                chk("game_over", GAME_OVER, (m_phase == 2) ? 1 : 0);
                chk("low_blink", LOW_BLINK,
                    ((m_low_age >= 0) && (((m_low_age / BH) % 2) == 0)) ? 1 : 0);
            end
        end
    end

    // Measures the length of each INVULN pulse.
    initial begin
        forever begin
            @(negedge CLK);
            if (INVULN) inv_run++;
            else if (inv_run > 0) begin
                last_inv_len = inv_run;
                inv_run = 0;
            end
        end
    end

    task automatic req(input bit is_dmg, input logic [3:0] amt, input bit exp_ack,
                       input int bound);
        bit got;
        got = 1'b0;
        @(negedge CLK);
        if (is_dmg) begin DMG_AMT = amt; DMG_REQ = 1'b1; end
        else begin HEAL_AMT = amt; HEAL_REQ = 1'b1; end
        for (int i = 1; i <= bound; i++) begin
            @(negedge CLK);
            if (is_dmg ? DMG_ACK : HEAL_ACK) begin
                got = 1'b1;
                chk(is_dmg ? "dmg_latency" : "heal_latency", i, 1);
                break;
            end
        end
        DMG_REQ  = 1'b0;
        HEAL_REQ = 1'b0;
        chk(is_dmg ? "dmg_ack_seen" : "heal_ack_seen", got, exp_ack);
    endtask

    task automatic wait_inv_low();
        for (int i = 0; i < 40; i++) begin
            if (!INVULN) break;
            @(negedge CLK);
        end
        chk("invuln_ends", INVULN, 0);
        @(negedge CLK);
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        int dcyc, hcyc;
        RST = 1'b0; START = 1'b0;
        DMG_REQ = 1'b0; DMG_AMT = 4'd0; HEAL_REQ = 1'b0; HEAL_AMT = 4'd0;
        #2 RST = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_hp", OUT_HP, 0);
        chk("rst_go", GAME_OVER, 0);

        // 1: requests in IDLE are ignored; START loads full HP
        req(1'b1, 4'd3, 1'b0, 6);
        req(1'b0, 4'd2, 1'b0, 6);
        start_pulse();
        chk("start_hp", OUT_HP, 10);
        chk("start_flags", {GAME_OVER, INVULN, LOW_BLINK}, 0);

        // 2: hit, invulnerability window, damage ignored while invulnerable
        req(1'b1, 4'd3, 1'b1, 10);
        chk("hit_hp", OUT_HP, 7);
        chk("hit_inv", INVULN, 1);
        req(1'b1, 4'd5, 1'b1, 10);
        chk("inv_dmg_hp", OUT_HP, 7);
        wait_inv_low();
        chk("inv_len", last_inv_len, 8);

        // 3: simultaneous requests, damage first; then saturating heal
        dcyc = 0; hcyc = 0;
        @(negedge CLK);
        DMG_AMT = 4'd2; HEAL_AMT = 4'd4; DMG_REQ = 1'b1; HEAL_REQ = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (DMG_REQ && DMG_ACK) begin
                dcyc = i; chk("arb_dmg_hp", OUT_HP, 5); DMG_REQ = 1'b0;
            end
            if (HEAL_REQ && HEAL_ACK) begin
                hcyc = i; chk("arb_heal_hp", OUT_HP, 9); HEAL_REQ = 1'b0;
            end
            if (!DMG_REQ && !HEAL_REQ) break;
        end
        DMG_REQ = 1'b0; HEAL_REQ = 1'b0;
        chk("arb_dmg_cyc", dcyc, 1);
        chk("arb_heal_cyc", hcyc, 2);
        req(1'b0, 4'd15, 1'b1, 10);
        chk("heal_sat", OUT_HP, 10);

        // 4: low-HP blink
        wait_inv_low();
        req(1'b1, 4'd6, 1'b1, 10);
        chk("hp4", OUT_HP, 4);
        wait_inv_low();
        req(1'b1, 4'd2, 1'b1, 10);
        chk("hp2", OUT_HP, 2);
        chk("blink_start", LOW_BLINK, 1);
        repeat (4) @(negedge CLK);
        chk("blink_low", LOW_BLINK, 0);
        repeat (4) @(negedge CLK);
        chk("blink_high", LOW_BLINK, 1);
        req(1'b0, 4'd5, 1'b1, 10);
        chk("heal_out_low", OUT_HP, 7);
        chk("blink_off", LOW_BLINK, 0);

        // 5: death, ignored requests, restart with a coincident heal
        wait_inv_low();
        req(1'b1, 4'd5, 1'b1, 10);
        chk("hp2b", OUT_HP, 2);
        wait_inv_low();
        req(1'b1, 4'd9, 1'b1, 10);
        chk("dead_hp", OUT_HP, 0);
        chk("dead_go", GAME_OVER, 1);
        chk("dead_flags", {INVULN, LOW_BLINK}, 0);
        req(1'b1, 4'd1, 1'b0, 6);
        req(1'b0, 4'd3, 1'b0, 6);
        @(negedge CLK);
        START = 1'b1; HEAL_AMT = 4'd1; HEAL_REQ = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("restart_hp", OUT_HP, 10);
        chk("restart_go", GAME_OVER, 0);
        chk("restart_no_ack", HEAL_ACK, 0);
        @(negedge CLK);
        chk("restart_heal_ack", HEAL_ACK, 1);
        chk("restart_heal_hp", OUT_HP, 10);
        HEAL_REQ = 1'b0;

        // 6: asynchronous reset during invulnerability
        req(1'b1, 4'd4, 1'b1, 10);
        chk("hp6", OUT_HP, 6);
        chk("hp6_inv", INVULN, 1);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_hp", OUT_HP, 0);
        chk("arst_inv", INVULN, 0);
        chk("arst_flags", {DMG_ACK, HEAL_ACK, GAME_OVER, LOW_BLINK}, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_after_rst", OUT_HP, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
